// File: rtl/muldiv_seq_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_seq_pkg
// Shared types and constants for the sequential multiply/divide unit:
//   word_t        64-bit operand/result word
//   muldiv_op_t   requested operation
//   md_state_t    sequencer FSM state
//   MULDIV_STEPS  number of iterative steps per operation
//   magnitude()   absolute value of a word when the op is signed
// -----------------------------------------------------------------------------
package muldiv_seq_pkg;

    typedef logic [63:0] word_t;

    typedef enum logic [2:0] {
        MD_MUL  = 3'd0,
        MD_DIV  = 3'd1,
        MD_DIVU = 3'd2,
        MD_REM  = 3'd3,
        MD_REMU = 3'd4
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } md_state_t;

    localparam int MULDIV_STEPS = 64;

    // Two's-complement negate wraps -2^63 onto itself, which is also its
    // correct unsigned magnitude.
    function automatic word_t magnitude(input word_t v, input logic is_signed);
        return (is_signed && v[63]) ? (~v + 64'd1) : v;
    endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// -----------------------------------------------------------------------------
// muldiv_seq_if
// Request/response bundle between the execute stage and muldiv_seq.
//   valid_i/op_i/a_i/b_i  request from execute stage
//   flush_i               pipeline flush
//   ack_i                 consumer takes the result
//   ready_o               sequencer idle, can accept
//   valid_o/result_o      result handshake
//   stall_o               stall request upstream
// Modports: master = execute stage side, slave = muldiv_seq side.
// -----------------------------------------------------------------------------
interface muldiv_seq_if;
    import muldiv_seq_pkg::*;

    logic       valid_i;
    muldiv_op_t op_i;
    word_t      a_i;
    word_t      b_i;
    logic       flush_i;
    logic       ack_i;
    logic       ready_o;
    logic       valid_o;
    word_t      result_o;
    logic       stall_o;

    modport master (
        output valid_i, op_i, a_i, b_i, flush_i, ack_i,
        input  ready_o, valid_o, result_o, stall_o
    );

    modport slave (
        input  valid_i, op_i, a_i, b_i, flush_i, ack_i,
        output ready_o, valid_o, result_o, stall_o
    );

endinterface

// File: rtl/muldiv_step.sv
// -----------------------------------------------------------------------------
// muldiv_step
// One combinational iteration of the sequential multiply/divide datapath.
//   is_mul  1: shift-add multiply step, 0: restoring divide step
//   hi      multiply: product accumulator   | divide: partial remainder
//   lo      multiply: shifted multiplicand  | divide: dividend/quotient shifter
//   dv      multiply: shifted multiplier    | divide: divisor magnitude
//   *_n     values after this step
// -----------------------------------------------------------------------------
module muldiv_step
    import muldiv_seq_pkg::*;
(
    input  logic  is_mul,
    input  word_t hi,
    input  word_t lo,
    input  word_t dv,
    output word_t hi_n,
    output word_t lo_n,
    output word_t dv_n
);

    logic [64:0] rem_sh;
    logic [64:0] diff;

    always_comb begin
        rem_sh = {hi, lo[63]};
        diff   = rem_sh - {1'b0, dv};
        hi_n   = hi;
        lo_n   = lo;
        dv_n   = dv;
        if (is_mul) begin
            hi_n = dv[0] ? (hi + lo) : hi;
            lo_n = {lo[62:0], 1'b0};
            dv_n = {1'b0, dv[63:1]};
        end else begin
            // Partial remainder stays below the divisor, so a borrow shows up
            // as bit 64 and the restored value always fits in 64 bits.
            lo_n = {lo[62:0], ~diff[64]};
            hi_n = diff[64] ? rem_sh[63:0] : diff[63:0];
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// -----------------------------------------------------------------------------
// muldiv_seq
// Sequential 64-bit multiply / divide / remainder unit, one step per cycle.
//   clk    system clock
//   reset  synchronous active-high reset
//   bus    muldiv_seq_if.slave request/response bundle
// Build option: define MULDIV_EARLY_OUT_EN to finish multiplies with a zero
// operand and divides by zero one cycle after accept. Results do not change.
//
// state | meaning
// IDLE  | ready for a request
// MUL   | shift-add multiply, 64 steps
// DIV   | restoring divide on magnitudes, 64 steps
// DONE  | result valid, waiting for ack_i
// -----------------------------------------------------------------------------
module muldiv_seq
    import muldiv_seq_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    muldiv_seq_if.slave  bus
);

    md_state_t  state, state_nxt;
    muldiv_op_t op_q;
    logic [6:0] cnt;
    word_t      hi_q, lo_q, dv_q;
    word_t      hi_n, lo_n, dv_n;
    word_t      result_q;
    word_t      step_res;
    word_t      early_res;
    logic       neg_quo, neg_rem, div0;
    logic       accept, busy, last_step, early;
    logic       is_mul_in, signed_in;

    assign is_mul_in = (bus.op_i == MD_MUL);
    assign signed_in = (bus.op_i == MD_DIV) || (bus.op_i == MD_REM);
    assign accept    = (state == IDLE) && bus.valid_i && !bus.flush_i;
    assign busy      = (state == MUL) || (state == DIV);
    assign last_step = busy && (cnt == 7'(MULDIV_STEPS - 1));

`ifdef MULDIV_EARLY_OUT_EN
    assign early = is_mul_in ? ((bus.a_i == '0) || (bus.b_i == '0))
                             : (bus.b_i == '0);
`else
    assign early = 1'b0;
`endif

    muldiv_step u_step (
        .is_mul (state == MUL),
        .hi     (hi_q),
        .lo     (lo_q),
        .dv     (dv_q),
        .hi_n   (hi_n),
        .lo_n   (lo_n),
        .dv_n   (dv_n)
    );

    // Sign correction happens on the final step, as the result enters DONE.
    // A zero divisor already yields an all-ones quotient magnitude and a
    // remainder of |a|; only the signed quotient must skip negation.
    always_comb begin
        step_res = hi_n;
        case (op_q)
            MD_MUL:  step_res = hi_n;
            MD_DIV:  step_res = div0 ? '1 : (neg_quo ? (~lo_n + 64'd1) : lo_n);
            MD_DIVU: step_res = lo_n;
            MD_REM:  step_res = neg_rem ? (~hi_n + 64'd1) : hi_n;
            MD_REMU: step_res = hi_n;
            default: step_res = hi_n;
        endcase
    end

    always_comb begin
        early_res = '0;
        if (bus.op_i == MD_DIV || bus.op_i == MD_DIVU) begin
            early_res = '1;
        end else if (bus.op_i == MD_REM || bus.op_i == MD_REMU) begin
            early_res = bus.a_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.valid_i) begin
                    if (early)          state_nxt = DONE;
                    else if (is_mul_in) state_nxt = MUL;
                    else                state_nxt = DIV;
                end
            end
            MUL, DIV: begin
                if (last_step) state_nxt = DONE;
            end
            DONE: begin
                if (bus.ack_i) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (bus.flush_i) state_nxt = IDLE;
    end

    always_comb begin
        bus.ready_o  = (state == IDLE);
        bus.valid_o  = (state == DONE);
        bus.stall_o  = (bus.valid_i && (state != IDLE)) || busy;
        bus.result_o = result_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= '0;
            result_q <= '0;
            op_q     <= MD_MUL;
            hi_q     <= '0;
            lo_q     <= '0;
            dv_q     <= '0;
            neg_quo  <= 1'b0;
            neg_rem  <= 1'b0;
            div0     <= 1'b0;
        end else if (accept) begin
            cnt     <= '0;
            op_q    <= bus.op_i;
            hi_q    <= '0;
            lo_q    <= magnitude(bus.a_i, signed_in);
            dv_q    <= magnitude(bus.b_i, signed_in);
            neg_quo <= signed_in && (bus.a_i[63] ^ bus.b_i[63]);
            neg_rem <= signed_in && bus.a_i[63];
            div0    <= (bus.b_i == '0);
            if (early) result_q <= early_res;
        end else if (busy && !bus.flush_i) begin
            cnt  <= cnt + 7'd1;
            hi_q <= hi_n;
            lo_q <= lo_n;
            dv_q <= dv_n;
            if (last_step) result_q <= step_res;
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// -----------------------------------------------------------------------------
// tb_muldiv_seq
// Self-checking bench for muldiv_seq: directed corner cases, flush/reset/hold
// scenarios and randomized operations against an arithmetic reference model.
// Honours MULDIV_EARLY_OUT_EN for the expected latency.
// -----------------------------------------------------------------------------
module tb_muldiv_seq;
    import muldiv_seq_pkg::*;

    localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    muldiv_seq_if bus();

    muldiv_seq dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_result(input muldiv_op_t op,
                                               input logic [63:0] a,
                                               input logic [63:0] b);
        logic signed [63:0] sa, sb;
        logic               ovf;
        sa  = a;
        sb  = b;
        ovf = (a == MIN64) && (b == '1);
        case (op)
            MD_MUL:  return a * b;
            MD_DIV:  return (b == 0) ? '1 : (ovf ? MIN64 : 64'(sa / sb));
            MD_DIVU: return (b == 0) ? '1 : a / b;
            MD_REM:  return (b == 0) ? a : (ovf ? 64'd0 : 64'(sa % sb));
            MD_REMU: return (b == 0) ? a : a % b;
            default: return '0;
        endcase
    endfunction

    function automatic int ref_latency(input muldiv_op_t op,
                                       input logic [63:0] a,
                                       input logic [63:0] b);
`ifdef MULDIV_EARLY_OUT_EN
        if (op == MD_MUL && (a == 0 || b == 0)) return 1;
        if (op != MD_MUL && b == 0) return 1;
`endif
        if (op == MD_MUL && a == 64'hDEAD && b == 64'hBEEF) return 65;
        return 65;
    endfunction

    function automatic logic [63:0] rnd_operand();
        case ($urandom_range(0, 6))
            0:       return '0;
            1:       return MIN64;
            2:       return '1;
            3:       return 64'($urandom_range(0, 50));
            4:       return -64'($urandom_range(1, 50));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // Issue one request, wait for the result, optionally hold DONE for a few
    // cycles while poking valid_i, then acknowledge.
    task automatic run_op(input muldiv_op_t op, input logic [63:0] a,
                          input logic [63:0] b, input int hold, input string tag);
        logic [63:0] exp;
        int          exp_lat;
        int          lat;
        int          busy_bad;
        exp     = ref_result(op, a, b);
        exp_lat = ref_latency(op, a, b);
        chk({tag, " ready_before"}, 64'(bus.ready_o), 64'd1);
        bus.valid_i = 1'b1;
        bus.op_i    = op;
        bus.a_i     = a;
        bus.b_i     = b;
        tick();
        bus.valid_i = 1'b0;
        bus.op_i    = muldiv_op_t'($urandom_range(0, 4));
        bus.a_i     = {$urandom, $urandom};
        bus.b_i     = {$urandom, $urandom};
        lat      = 1;
        busy_bad = 0;
        while (!bus.valid_o && lat < 100) begin
            if (bus.ready_o || !bus.stall_o) busy_bad++;
            tick();
            lat++;
        end
        chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, " result"}, bus.result_o, exp);
        chk({tag, " busy_flags"}, 64'(busy_bad), 64'd0);
        chk({tag, " done_ready_stall"}, {62'd0, bus.ready_o, bus.stall_o}, 64'd0);
        for (int i = 0; i < hold; i++) begin
            bus.valid_i = 1'b1;
            bus.op_i    = MD_DIVU;
            tick();
            chk({tag, " hold_valid"}, 64'(bus.valid_o), 64'd1);
            chk({tag, " hold_result"}, bus.result_o, exp);
            chk({tag, " hold_stall"}, 64'(bus.stall_o), 64'd1);
        end
        bus.ack_i = 1'b1;
        tick();
        bus.ack_i   = 1'b0;
        bus.valid_i = 1'b0;
        chk({tag, " ack_idle"}, {62'd0, bus.ready_o, bus.valid_o}, 64'd2);
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        reset       = 1'b1;
        bus.valid_i = 1'b0;
        bus.op_i    = MD_MUL;
        bus.a_i     = '0;
        bus.b_i     = '0;
        bus.flush_i = 1'b0;
        bus.ack_i   = 1'b0;
        repeat (3) tick();
        chk("reset_ready",  64'(bus.ready_o),  64'd1);
        chk("reset_valid",  64'(bus.valid_o),  64'd0);
        chk("reset_stall",  64'(bus.stall_o),  64'd0);
        chk("reset_result", bus.result_o,      64'd0);
        reset = 1'b0;
        tick();

        run_op(MD_MUL,  64'd7,   -64'd3, 0, "mul_7_m3");
        run_op(MD_DIV,  -64'd20, 64'd3,  0, "div_m20_3");
        run_op(MD_REM,  -64'd20, 64'd3,  0, "rem_m20_3");
        run_op(MD_DIVU, 64'd20,  64'd3,  0, "divu_20_3");
        run_op(MD_DIVU, 64'd5,   64'd0,  0, "divu_by0");
        run_op(MD_REMU, 64'd5,   64'd0,  0, "remu_by0");
        run_op(MD_DIV,  -64'd9,  64'd0,  0, "div_by0");
        run_op(MD_REM,  -64'd9,  64'd0,  0, "rem_by0");
        run_op(MD_DIV,  MIN64,   '1,     0, "div_ovf");
        run_op(MD_REM,  MIN64,   '1,     0, "rem_ovf");
        run_op(MD_MUL,  64'd0,   64'd77, 0, "mul_zero");

        // flush together with valid_i in IDLE must not start anything
        bus.valid_i = 1'b1;
        bus.flush_i = 1'b1;
        bus.op_i    = MD_MUL;
        bus.a_i     = 64'd3;
        bus.b_i     = 64'd4;
        tick();
        bus.valid_i = 1'b0;
        bus.flush_i = 1'b0;
        chk("flush_idle_ready", 64'(bus.ready_o), 64'd1);

        // flush mid-multiply at cycle +30
        bus.valid_i = 1'b1;
        bus.op_i    = MD_MUL;
        bus.a_i     = 64'd123;
        bus.b_i     = 64'd456;
        tick();
        bus.valid_i = 1'b0;
        for (int i = 2; i <= 30; i++) tick();
        chk("flush_pre_busy", 64'(bus.ready_o), 64'd0);
        bus.flush_i = 1'b1;
        tick();
        bus.flush_i = 1'b0;
        chk("flush_valid", 64'(bus.valid_o), 64'd0);
        chk("flush_ready", 64'(bus.ready_o), 64'd1);
        run_op(MD_MUL, 64'd2, 64'd3, 0, "flush_new_mul");

        // DONE held five cycles with valid_i poking
        run_op(MD_DIV, 64'd1000, -64'd7, 5, "hold_div");

        // reset at step 40 of a divide
        bus.valid_i = 1'b1;
        bus.op_i    = MD_DIV;
        bus.a_i     = 64'd99999;
        bus.b_i     = 64'd17;
        tick();
        bus.valid_i = 1'b0;
        for (int i = 2; i <= 40; i++) tick();
        reset = 1'b1;
        tick();
        chk("rst40_ready",  64'(bus.ready_o), 64'd1);
        chk("rst40_valid",  64'(bus.valid_o), 64'd0);
        chk("rst40_stall",  64'(bus.stall_o), 64'd0);
        chk("rst40_result", bus.result_o,     64'd0);
        reset = 1'b0;
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 80; i++) begin
                tick();
                if (bus.valid_o) seen++;
            end
            chk("rst40_no_valid", 64'(seen), 64'd0);
        end

        for (int n = 0; n < 40; n++) begin
            muldiv_op_t  op;
            logic [63:0] a, b;
            op = muldiv_op_t'($urandom_range(0, 4));
            a  = rnd_operand();
            b  = rnd_operand();
            run_op(op, a, b, 0, $sformatf("rnd%0d_op%0d", n, op));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
